// File: rtl/bp_nonsynth_io_responder.sv
// Bench-side I/O target: services uncached io_cmd reads/writes against a dword backing
// store and per-core freeze registers, returning one response per command after a fixed delay.
module bp_nonsynth_io_responder #(
    parameter int paddr_width_p     = 40,
    parameter int cce_block_width_p = 512,
    parameter int lce_id_width_p    = 4,
    parameter int lce_assoc_p       = 8,
    parameter int dword_width_p     = 64,
    parameter int num_core_p        = 4,
    parameter int mem_els_p         = 1024,
    parameter int resp_delay_p      = 0,
    localparam int payload_width_lp     = lce_id_width_p + $clog2(lce_assoc_p),
    localparam int header_width_lp      = 4 + paddr_width_p + 3 + payload_width_lp,
    localparam int cce_mem_msg_width_lp = header_width_lp + cce_block_width_p
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
    input  logic                            io_cmd_v_i,
    output logic                            io_cmd_yumi_o,
    output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
    output logic                            io_resp_v_o,
    input  logic                            io_resp_ready_i,
    output logic [num_core_p-1:0]           freeze_o,
    output logic                            err_o
);
    // Message layout, LSB first: data, payload, size, addr, msg_type
    localparam int size_lsb_lp  = cce_block_width_p + payload_width_lp;
    localparam int addr_lsb_lp  = size_lsb_lp + 3;
    localparam int type_lsb_lp  = addr_lsb_lp + paddr_width_p;
    localparam int idx_width_lp = $clog2(mem_els_p);
    localparam int lanes_lp     = dword_width_p / 8;

    localparam logic [3:0]  e_cce_mem_uc_wr      = 4'd3;
    localparam logic [3:0]  cfg_dev_gp           = 4'd2;
    localparam logic [19:0] bp_cfg_reg_freeze_gp = 20'h8;

    typedef enum logic [1:0] {e_ready, e_delay, e_resp} state_e;

    state_e                          state_reg, state_next;
    logic [7:0]                      cnt_reg, cnt_next;
    logic [cce_mem_msg_width_lp-1:0] resp_reg;
    logic [num_core_p-1:0]           freeze_reg, freeze_next;
    logic                            err_reg;
    logic [dword_width_p-1:0]        mem [mem_els_p];

    logic [3:0]               cmd_type;
    logic [paddr_width_p-1:0] cmd_addr;
    logic [2:0]               cmd_size;
    logic [dword_width_p-1:0] cmd_data;
    logic [6:0]               cmd_cce;
    logic                     is_cfg, cce_ok, mem_ok, oor, is_wr, mem_we, freeze_bit;
    logic [num_core_p-1:0]    cce_sel;
    logic [idx_width_lp-1:0]  mem_idx;
    logic [1:0]               size_log;
    logic [2:0]               offset;
    logic [3:0]               nbytes;
    logic [lanes_lp-1:0]      byte_en;
    logic [dword_width_p-1:0] wr_data, rd_shift, rd_mask, rd_data;
    logic                     unused_data_bits;

    assign cmd_type = io_cmd_i[type_lsb_lp +: 4];
    assign cmd_addr = io_cmd_i[addr_lsb_lp +: paddr_width_p];
    assign cmd_size = io_cmd_i[size_lsb_lp +: 3];
    assign cmd_data = io_cmd_i[dword_width_p-1:0];
    assign unused_data_bits = ^io_cmd_i[cce_block_width_p-1:dword_width_p];

    // Address viewed as {nonlocal, cce, dev, dev_addr}
    assign cmd_cce = cmd_addr[30:24];
    assign is_cfg  = (cmd_addr[paddr_width_p-1:31] == '0)
                  && (cmd_addr[23:20] == cfg_dev_gp)
                  && (cmd_addr[19:0] == bp_cfg_reg_freeze_gp);
    assign cce_ok  = ({25'b0, cmd_cce} < 32'(num_core_p));
    assign mem_ok  = (cmd_addr[paddr_width_p-1:idx_width_lp+3] == '0);
    assign oor     = is_cfg ? !cce_ok : !mem_ok;
    assign is_wr   = (cmd_type == e_cce_mem_uc_wr);
    assign mem_idx = cmd_addr[3 +: idx_width_lp];

    // Sizes beyond a dword are clamped to a full dword
    assign size_log = (cmd_size > 3'd3) ? 2'd3 : cmd_size[1:0];
    assign offset   = cmd_addr[2:0] & (3'b111 << size_log);
    assign nbytes   = 4'd1 << size_log;
    assign wr_data  = cmd_data << {offset, 3'b000};
    assign rd_shift = mem[mem_idx] >> {offset, 3'b000};

    for (genvar gi = 0; gi < lanes_lp; gi++) begin : g_byte_en
        assign byte_en[gi] = ({1'b0, offset} <= 4'(gi)) && (4'(gi) < ({1'b0, offset} + nbytes));
    end

    for (genvar gi = 0; gi < num_core_p; gi++) begin : g_freeze
        assign cce_sel[gi]     = (cmd_cce == 7'(gi));
        assign freeze_next[gi] = (io_cmd_yumi_o && is_cfg && is_wr && cce_sel[gi])
                               ? cmd_data[0] : freeze_reg[gi];
    end
    assign freeze_bit = |(freeze_reg & cce_sel);

    always_comb begin
        rd_mask = '1;
        case (size_log)
            2'd0: rd_mask = dword_width_p'(64'hFF);
            2'd1: rd_mask = dword_width_p'(64'hFFFF);
            2'd2: rd_mask = dword_width_p'(64'hFFFF_FFFF);
            default: rd_mask = '1;
        endcase
    end

    assign rd_data = (oor || is_wr) ? '0
                   : is_cfg ? {{(dword_width_p-1){1'b0}}, freeze_bit}
                   : (rd_shift & rd_mask);

    assign mem_we = io_cmd_yumi_o && is_wr && !is_cfg && mem_ok;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < lanes_lp; b++) begin
                if (byte_en[b]) mem[mem_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg  <= e_ready;
            cnt_reg    <= 8'd0;
            resp_reg   <= '0;
            freeze_reg <= '1;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            freeze_reg <= freeze_next;
            if (io_cmd_yumi_o) begin
                resp_reg <= {io_cmd_i[cce_mem_msg_width_lp-1:cce_block_width_p],
                             cce_block_width_p'(rd_data)};
                err_reg  <= err_reg | oor;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        io_cmd_yumi_o = 1'b0;
        io_resp_v_o   = 1'b0;
        unique case (state_reg)
            e_ready: begin
                io_cmd_yumi_o = io_cmd_v_i & reset_n_i;
                if (io_cmd_yumi_o) begin
                    cnt_next   = 8'(resp_delay_p);
                    state_next = (resp_delay_p > 0) ? e_delay : e_resp;
                end
            end
            e_delay: begin
                cnt_next = cnt_reg - 8'd1;
                if (cnt_reg == 8'd1) state_next = e_resp;
            end
            e_resp: begin
                io_resp_v_o = 1'b1;
                if (io_resp_ready_i) state_next = e_ready;
            end
            default: state_next = e_ready;
        endcase
    end

    assign io_resp_o = resp_reg;
    assign freeze_o  = freeze_reg;
    assign err_o     = err_reg;

endmodule

// File: tb/tb_bp_nonsynth_io_responder.sv
// Randomized bench for bp_nonsynth_io_responder: a byte-level memory/freeze model predicts
// every response, and a negedge compare process checks the handshake and outputs each cycle.
module tb_bp_nonsynth_io_responder;
    localparam int PA = 40, CBW = 128, LID = 4, ASSOC = 8, NC = 4, MEM_ELS = 1024, DLY = 3;
    localparam int PAYW = LID + $clog2(ASSOC);
    localparam int MSG_W = 4 + PA + 3 + PAYW + CBW;
    localparam int SIZE_LSB = CBW + PAYW, ADDR_LSB = SIZE_LSB + 3, TYPE_LSB = ADDR_LSB + PA;
    localparam int MEM_BYTES = MEM_ELS * 8;
    localparam int TMO = 50;
    localparam logic [3:0] UC_RD = 4'd2, UC_WR = 4'd3;
    localparam logic [2:0] SZ1 = 3'd0, SZ2 = 3'd1, SZ4 = 3'd2, SZ8 = 3'd3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [MSG_W-1:0] cmd;
    logic             cmd_v, cmd_yumi, resp_v, resp_ready, err;
    logic [MSG_W-1:0] resp;
    logic [NC-1:0]    freeze;

    bp_nonsynth_io_responder #(
        .paddr_width_p(PA), .cce_block_width_p(CBW), .lce_id_width_p(LID),
        .lce_assoc_p(ASSOC), .dword_width_p(64), .num_core_p(NC),
        .mem_els_p(MEM_ELS), .resp_delay_p(DLY)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .io_cmd_i(cmd), .io_cmd_v_i(cmd_v), .io_cmd_yumi_o(cmd_yumi),
        .io_resp_o(resp), .io_resp_v_o(resp_v), .io_resp_ready_i(resp_ready),
        .freeze_o(freeze), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0, n_txn = 0;

    task automatic chk(input string nm, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [MSG_W-1:0] pack(input logic [3:0] t, input logic [PA-1:0] a,
                                              input logic [2:0] s, input logic [63:0] d);
        logic [MSG_W-1:0] m;
        m = '0;
        m[TYPE_LSB +: 4]  = t;
        m[ADDR_LSB +: PA] = a;
        m[SIZE_LSB +: 3]  = s;
        m[CBW +: PAYW]    = 7'h2B;
        m[63:0]           = d;
        return m;
    endfunction

    function automatic logic [PA-1:0] cfg_addr(input int cce);
        return {9'b0, 7'(cce), 4'h2, 20'h8};
    endfunction

    // Reference model: byte-addressed store, freeze bits, sticky error, one command in flight
    logic [7:0]       m_mem [MEM_BYTES];
    logic [NC-1:0]    m_freeze;
    logic             m_err;
    bit               m_busy = 0;
    int               m_acc;
    logic [MSG_W-1:0] m_resp;

    task automatic model_accept(input logic [MSG_W-1:0] c);
        logic [3:0]    t;
        logic [PA-1:0] a;
        logic [63:0]   d, rd;
        int nb, base, off, cce;
        t  = c[TYPE_LSB +: 4];
        a  = c[ADDR_LSB +: PA];
        d  = c[63:0];
        nb = 1 << int'(c[SIZE_LSB +: 3]);
        rd = '0;
        if (a[39:31] == 0 && a[23:20] == 4'h2 && a[19:0] == 20'h8) begin
            cce = int'(a[30:24]);
            if (cce >= NC) m_err = 1'b1;
            else if (t == UC_WR) m_freeze[cce] = d[0];
            else rd = 64'(m_freeze[cce]);
        end else if (a < MEM_BYTES) begin
            base = int'(a) - int'(a) % 8;
            off  = ((int'(a) % 8) / nb) * nb;
            for (int b = 0; b < nb; b++) begin
                if (t == UC_WR) m_mem[base + off + b] = d[8*b +: 8];
                else rd[8*b +: 8] = m_mem[base + off + b];
            end
        end else begin
            m_err = 1'b1;
        end
        m_resp = {c[MSG_W-1:CBW], CBW'(rd)};
        m_busy = 1;
        m_acc  = cyc;
    endtask

    logic exp_y, exp_v;
    always @(negedge clk) begin
        if (!reset_n) begin
            m_busy   = 0;
            m_freeze = '1;
            m_err    = 1'b0;
            chk("reset_yumi", cmd_yumi, 1'b0);
            chk("reset_resp_v", resp_v, 1'b0);
            chk("reset_freeze", freeze, m_freeze);
            chk("reset_err", err, m_err);
        end else begin
            exp_y = cmd_v && !m_busy;
            exp_v = m_busy && (cyc >= m_acc + 1 + DLY);
            chk("yumi", cmd_yumi, exp_y);
            chk("resp_v", resp_v, exp_v);
            chk("freeze", freeze, m_freeze);
            chk("err", err, m_err);
            if (exp_v) chk("resp_msg", resp, m_resp);
            if (exp_v && resp_ready) begin
                n_txn++;
                $display("txn %0d: type=%0d addr=%h size=%0d data=%h", n_txn,
                         m_resp[TYPE_LSB +: 4], m_resp[ADDR_LSB +: PA], m_resp[SIZE_LSB +: 3],
                         m_resp[63:0]);
                m_busy = 0;
            end else if (exp_y) begin
                model_accept(cmd);
            end
        end
        cyc++;
    end

    task automatic do_cmd(input logic [3:0] t, input logic [PA-1:0] a, input logic [2:0] s,
                          input logic [63:0] d, output logic [MSG_W-1:0] r, output int lat);
        int k;
        @(posedge clk); #1;
        cmd   = pack(t, a, s, d);
        cmd_v = 1'b1;
        k = 0;
        @(negedge clk);
        while (!cmd_yumi && k < TMO) begin @(negedge clk); k++; end
        chk("yumi_wait", cmd_yumi, 1'b1);
        @(posedge clk); #1;
        cmd_v = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!resp_v && lat < TMO) begin @(negedge clk); lat++; end
        chk("resp_wait", resp_v, 1'b1);
        r = resp;
    endtask

    logic [MSG_W-1:0] r, held;
    int lat, k, sel, nv;
    logic [3:0] fexp;
    logic [PA-1:0] ra;
    logic [3:0] rt;

    initial begin
        reset_n = 1'b0; cmd_v = 1'b0; cmd = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_freeze_lit", freeze, 4'hF);
        chk("rst_resp_v_lit", resp_v, 1'b0);
        chk("rst_err_lit", err, 1'b0);
        @(posedge clk); #1 reset_n = 1'b1;

        do_cmd(UC_WR, 0, SZ8, 64'h1122334455667788, r, lat);
        chk("wr_resp_type", r[TYPE_LSB +: 4], UC_WR);
        chk("wr_resp_data", r[CBW-1:0], '0);
        chk("latency", lat, 1 + DLY);
        do_cmd(UC_RD, 0, SZ8, 0, r, lat);
        chk("rd8_data", r[CBW-1:0], 64'h1122334455667788);

        do_cmd(UC_WR, 3, SZ1, 64'hAB, r, lat);
        do_cmd(UC_RD, 0, SZ8, 0, r, lat);
        chk("sub_rd8", r[CBW-1:0], 64'h11223344AB667788);
        do_cmd(UC_RD, 2, SZ2, 0, r, lat);
        chk("sub_rd2", r[CBW-1:0], 64'hAB66);
        do_cmd(UC_RD, 5, SZ4, 0, r, lat);
        chk("sub_rd4", r[CBW-1:0], 64'h11223344);

        for (int i = 0; i < NC; i++) begin
            do_cmd(UC_WR, cfg_addr(i), SZ8, 0, r, lat);
            fexp = 4'hF << (i + 1);
            chk("freeze_clear", freeze, fexp);
        end
        do_cmd(UC_RD, cfg_addr(0), SZ8, 0, r, lat);
        chk("freeze_rd", r[CBW-1:0], '0);

        do_cmd(UC_RD, PA'(MEM_BYTES), SZ8, 0, r, lat);
        chk("oor_data", r[CBW-1:0], '0);
        chk("oor_err", err, 1'b1);
        do_cmd(UC_RD, 0, SZ8, 0, r, lat);
        chk("post_oor_rd", r[CBW-1:0], 64'h11223344AB667788);
        chk("err_sticky", err, 1'b1);

        // Backpressure: second command waits behind a stalled response
        @(posedge clk); #1;
        resp_ready = 1'b0; cmd = pack(UC_RD, 0, SZ8, 0); cmd_v = 1'b1;
        k = 0;
        @(negedge clk);
        while (!cmd_yumi && k < TMO) begin @(negedge clk); k++; end
        @(posedge clk); #1 cmd = pack(UC_RD, 0, SZ4, 0);
        lat = 1;
        @(negedge clk);
        while (!resp_v && lat < TMO) begin @(negedge clk); lat++; end
        chk("bp_latency", lat, 1 + DLY);
        held = resp;
        repeat (5) begin
            @(negedge clk);
            chk("bp_no_yumi", cmd_yumi, 1'b0);
            chk("bp_stable", resp, held);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        chk("hs_no_yumi", cmd_yumi, 1'b0);
        @(negedge clk);
        chk("accept_after_hs", cmd_yumi, 1'b1);
        @(posedge clk); #1 cmd_v = 1'b0;
        repeat (8) @(negedge clk);

        // Asynchronous reset while the response is held valid
        resp_ready = 1'b0;
        do_cmd(UC_RD, 0, SZ8, 0, r, lat);
        chk("arst_pre_v", resp_v, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk("arst_resp_v", resp_v, 1'b0);
        chk("arst_freeze", freeze, 4'hF);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        resp_ready = 1'b1;

        // Asynchronous reset during the delay window
        @(posedge clk); #1 cmd = pack(UC_RD, 0, SZ8, 0); cmd_v = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 cmd_v = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        nv = 0;
        repeat (10) begin @(negedge clk); if (resp_v) nv++; end
        chk("no_resp_after_arst", nv, 0);

        for (int i = 0; i < 32; i++) do_cmd(UC_WR, PA'(i * 8), SZ8, {$urandom, $urandom}, r, lat);

        for (int n = 0; n < 1500; n++) begin
            @(posedge clk); #1;
            sel = int'($urandom % 20);
            rt  = ($urandom % 2) ? UC_WR : UC_RD;
            if (sel < 14) begin
                ra = PA'($urandom % 256);
                if (sel == 13) rt = 4'($urandom % 2);
            end else if (sel < 18) begin
                ra = cfg_addr(int'($urandom % 6));
            end else begin
                ra = PA'(MEM_BYTES + ($urandom % 4096));
            end
            cmd = pack(rt, ra, 3'($urandom % 4), {$urandom, $urandom});
            cmd[CBW-1:64] = {$urandom, $urandom};
            cmd_v = ($urandom % 3) != 0;
            resp_ready = ($urandom % 4) != 0;
        end
        @(posedge clk); #1 cmd_v = 1'b0; resp_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bp_nonsynth_io_responder.md
Name: bp_nonsynth_io_responder

Overview:
- Non-synthesizable I/O-side responder: the target end of the uncached io_cmd/io_resp link driven by the NBF loader and by core uncached traffic.
- Accepts bp_cce_mem_msg_s commands (e_cce_mem_uc_wr / e_cce_mem_uc_rd), services them against a dword-wide backing store plus per-core freeze config registers, and returns one response per command after a programmable delay.
- Used in testbenches in place of the real I/O complex so that loader/boot sequences can be checked stand-alone.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p, dword_width_p (64), num_core_p.
- mem_els_p, 1024, backing-store depth in dwords (power of 2); byte capacity is mem_els_p*8.
- resp_delay_p, 0, extra cycles between command accept and response valid (0..255).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- io_cmd_i  in  cce_mem_msg_width_lp  command message (bp_cce_mem_msg_s)
- io_cmd_v_i  in  1  command valid
- io_cmd_yumi_o  out  1  command consumed this cycle
- io_resp_o  out  cce_mem_msg_width_lp  response message
- io_resp_v_o  out  1  response valid
- io_resp_ready_i  in  1  sink ready
- freeze_o  out  num_core_p  per-core freeze register value
- err_o  out  1  sticky: out-of-range access seen

Behaviour:
- Reset: asynchronous, active-low. While reset_n_i=0: state=READY, io_resp_v_o=0, io_cmd_yumi_o=0, freeze_o=all ones, err_o=0, delay counter=0, response register=0. Backing store is not reset. Reset asserted mid-transaction drops any pending response.
- States:
  - READY: io_cmd_yumi_o = io_cmd_v_i (combinational). On yumi: execute the command, capture the response, load the counter with resp_delay_p; go to DELAY if resp_delay_p>0, else to RESP.
  - DELAY: decrement the counter each cycle; go to RESP on the cycle the counter reaches 1->0.
  - RESP: io_resp_v_o=1. On io_resp_ready_i go to READY.
  - One command in flight. No accept in RESP or DELAY, including the cycle in which the response handshakes.
  - Throughput with resp_delay_p=0: one command per 2 cycles. Accept-to-valid latency is 1+resp_delay_p cycles.
- Decode uses header.addr as bp_local_addr_s:
  - Config freeze: nonlocal==0, dev==cfg_dev_gp and addr==bp_cfg_reg_freeze_gp.
    - uc_wr sets freeze_o[cce] = data[0].
    - uc_rd returns {63'b0, freeze_o[cce]}.
    - A cce >= num_core_p is out-of-range.
  - Memory: any other address < mem_els_p*8. Index = addr[3 +: log2(mem_els_p)]; byte offset = addr[2:0] aligned down to size.
    - Size e_mem_size_1/2/4/8 = 1/2/4/8 bytes.
    - uc_wr writes data[size*8-1:0] into bytes offset..offset+size-1 of the entry. Other bytes are unchanged.
    - uc_rd returns the selected bytes zero-extended in data[63:0].
  - Out-of-range (memory addr >= mem_els_p*8, or bad cce): write dropped, read returns 0, err_o set at the accept edge and held until reset.
- Response message:
  - header copied from the command: msg_type, addr, size, payload (lce_id preserved).
  - data: read data for uc_rd, all zero for uc_wr. Bits above dword_width_p are zero.
  - io_resp_o holds stable while io_resp_v_o=1 and is unchanged until the next accept.
- Other msg_type values: treated as uc_rd of the decoded address.
- Write visibility: a write takes effect at its accept edge, so the next command's read sees it.

Test Plan:
- Reset: hold reset_n_i=0 -> freeze_o=all ones, io_resp_v_o=0, err_o=0. Release, then uc_wr size 8 addr 0x0 data 0x1122334455667788 -> yumi same cycle; resp valid next cycle, msg_type uc_wr, data 0. Then uc_rd size 8 addr 0x0 -> data 0x1122334455667788.
- Sub-word: uc_wr size 1 addr 0x3 data 0xAB over the previous word -> uc_rd size 8 addr 0 returns 0x11223344AB667788. uc_rd size 2 addr 0x2 returns 0xAB66. uc_rd size 4 addr 0x5 (aligns to 0x4) returns 0x11223344.
- Freeze: for each core i, uc_wr to cfg freeze addr cce=i data 0 -> freeze_o bit i clears in core order, e.g. 4'b1111 -> 4'b0000 for num_core_p=4. uc_rd returns 0.
- Delay and backpressure: resp_delay_p=3, io_resp_ready_i low for 5 cycles -> valid 4 cycles after accept, held stable, no yumi until the handshake; the next command is accepted 1 cycle after the handshake.
- Out-of-range: uc_rd addr mem_els_p*8 -> data 0, err_o=1 sticky. Subsequent valid accesses still work.
- Async reset mid-DELAY: assert reset_n_i asynchronously -> io_resp_v_o drops immediately, state=READY, and no response is emitted after release.
